regfile_port_master: RTL and testbench

- Initiator for the MIPS 32x32 register file: the block that drives RegisterFile's read_reg1/read_reg2/RegWrite/write_reg/write_data ports and samples read_data1/read_data2.
- Accepts read/write commands over a valid/ready interface and buffers them in a small in-order FIFO.
- Sequences each command onto the register-file ports and returns one response per command over a valid/ready interface.
- Used as the register-file access agent for debug/boot-load and for directed register-file verification.

---
 rtl/regfile_port_master.sv | 163 ++++++++++++++++
 tb/tb_regfile_port_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_master.sv
// regfile_port_master
// Command-driven initiator for a MIPS 32x32 register file. Read/write
// commands arrive over a valid/ready channel, are buffered in an in-order
// FIFO, issued one at a time onto the register-file ports, and answered
// with one response each over a second valid/ready channel.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr1/2, wdata   command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_data1/2, rsp_err            response payload
//   rf_read_reg1/2, rf_read_data1/2 register-file read ports
//   rf_RegWrite, rf_write_reg/data  register-file write port
//   fifo_count                      entries held in the command FIFO
//   err_count                       rejected writes (saturating at 255)
module regfile_port_master #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [ADDR_W-1:0]             cmd_addr1,
    input  logic [ADDR_W-1:0]             cmd_addr2,
    input  logic [DATA_W-1:0]             cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data1,
    output logic [DATA_W-1:0]             rsp_data2,
    output logic                          rsp_err,
    output logic [ADDR_W-1:0]             rf_read_reg1,
    output logic [ADDR_W-1:0]             rf_read_reg2,
    input  logic [DATA_W-1:0]             rf_read_data1,
    input  logic [DATA_W-1:0]             rf_read_data2,
    output logic                          rf_RegWrite,
    output logic [ADDR_W-1:0]             rf_write_reg,
    output logic [DATA_W-1:0]             rf_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    err_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] addr2;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    cmd_t             r_iss;
    logic [DATA_W-1:0] r_rsp_data1;
    logic [DATA_W-1:0] r_rsp_data2;
    logic             r_rsp_err;
    logic [7:0]       r_err_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_iss_rej;

    // cmd_ready comes from the registered count only, so a pop while full
    // frees the slot for the next cycle rather than combinationally.
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = !w_empty && ((r_state == S_IDLE) ||
                                    (r_state == S_RESP && rsp_ready));
    assign w_iss_rej = r_iss.write && (r_iss.addr1 == '0);

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{cmd_write, cmd_addr1, cmd_addr2, cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = w_empty ? S_IDLE : S_ISSUE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Issue register feeds the rf_* buses directly, so they hold their
    // last value until the next command is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_iss <= '0;
        else if (w_pop) r_iss <= r_mem[r_rptr];
    end

    // Response capture happens at the edge closing the ISSUE cycle; the
    // register file read is combinational, so its data is valid then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data1 <= '0;
            r_rsp_data2 <= '0;
            r_rsp_err   <= 1'b0;
            r_err_count <= '0;
        end else if (r_state == S_ISSUE) begin
            r_rsp_data1 <= r_iss.write ? r_iss.wdata : rf_read_data1;
            r_rsp_data2 <= r_iss.write ? '0          : rf_read_data2;
            r_rsp_err   <= w_iss_rej;
            if (w_iss_rej && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
        end
    end

    // Decoded from the state register so reset drops it immediately.
    assign rf_RegWrite   = (r_state == S_ISSUE) && r_iss.write && (r_iss.addr1 != '0);
    assign rf_read_reg1  = r_iss.addr1;
    assign rf_read_reg2  = r_iss.addr2;
    assign rf_write_reg  = r_iss.addr1;
    assign rf_write_data = r_iss.wdata;

    assign cmd_ready  = !w_full;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data1  = r_rsp_data1;
    assign rsp_data2  = r_rsp_data2;
    assign rsp_err    = r_rsp_err;
    assign fifo_count = r_count;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_regfile_port_master.sv
// Testbench for regfile_port_master: a behavioural register file sits on
// the rf_* ports; a command-level model predicts every response in order.
module tb_regfile_port_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr1;
    logic [4:0]  cmd_addr2;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic        rsp_err;
    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        rf_RegWrite;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [2:0]  fifo_count;
    logic [7:0]  err_count;

    logic rdy_fix;
    logic rdy_rand;
    logic rnd_bit;
    assign rsp_ready = rdy_rand ? rnd_bit : rdy_fix;

    always #5 clk = ~clk;

    regfile_port_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_RegWrite(rf_RegWrite), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data),
        .fifo_count(fifo_count), .err_count(err_count)
    );

    // ---------------- behavioural register file ----------------
    logic [31:0] rf_mem [32];
    int          n_pulse = 0;
    int          n_wr0   = 0;
    logic [4:0]  last_wreg = '0;
    logic [31:0] last_wdata = '0;

    assign rf_read_data1 = (rf_read_reg1 == 5'd0) ? 32'd0 : rf_mem[rf_read_reg1];
    assign rf_read_data2 = (rf_read_reg2 == 5'd0) ? 32'd0 : rf_mem[rf_read_reg2];

    always @(posedge clk) begin
        if (rf_RegWrite) begin
            n_pulse    <= n_pulse + 1;
            last_wreg  <= rf_write_reg;
            last_wdata <= rf_write_data;
            if (rf_write_reg == 5'd0) n_wr0 <= n_wr0 + 1;
            else rf_mem[rf_write_reg] <= rf_write_data;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
        logic [7:0]  ec;
    } rsp_t;

    logic [31:0] mdl [32];
    rsp_t        exp_q [$];
    time         hs_times [$];
    int          m_ec = 0;
    int          exp_pulses = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Commands complete strictly in order, so the whole response can be
    // predicted at acceptance time from the architectural register state.
    task automatic model_push(input logic w, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d);
        rsp_t e;
        if (w) begin
            e.d1 = d;
            e.d2 = 32'd0;
            e.err = (a1 == 5'd0);
            if (a1 == 5'd0) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
            else begin
                mdl[a1] = d;
                exp_pulses++;
            end
        end else begin
            e.d1 = (a1 == 5'd0) ? 32'd0 : mdl[a1];
            e.d2 = (a2 == 5'd0) ? 32'd0 : mdl[a2];
            e.err = 1'b0;
        end
        e.ec = 8'(m_ec);
        exp_q.push_back(e);
    endtask

    // Scoreboard: samples both handshakes mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (cmd_valid && cmd_ready)
                model_push(cmd_write, cmd_addr1, cmd_addr2, cmd_wdata);
            if (rsp_valid && rsp_ready) begin
                hs_times.push_back($time);
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data1", rsp_data1, e.d1);
                    chk("rsp_data2", rsp_data2, e.d2);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_err_count", 32'(err_count), 32'(e.ec));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic w, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr1 = a1;
        cmd_addr2 = a2;
        cmd_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("push_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !rsp_valid && fifo_count == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] saved7;
    int          p0;
    logic        found;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr1 = '0; cmd_addr2 = '0; cmd_wdata = '0;
        rdy_fix = 1'b1; rdy_rand = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
            mdl[i]    = rf_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_regwrite", 32'(rf_RegWrite), 32'd0);
        chk("rst_write_reg", 32'(rf_write_reg), 32'd0);
        chk("rst_rsp_data1", rsp_data1, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // write reg2 = 13
        p0 = n_pulse;
        push(1'b1, 5'd2, 5'd0, 32'd13);
        drain();
        chk("w2_pulses", 32'(n_pulse - p0), 32'd1);
        chk("w2_wreg", 32'(last_wreg), 32'd2);
        chk("w2_wdata", last_wdata, 32'd13);

        // write reg0 rejected, then read reg0
        p0 = n_pulse;
        push(1'b1, 5'd0, 5'd0, 32'd13);
        push(1'b0, 5'd0, 5'd0, 32'd0);
        drain();
        chk("w0_pulses", 32'(n_pulse - p0), 32'd0);
        chk("w0_err_count", 32'(err_count), 32'd1);

        // read-after-write, back to back
        push(1'b1, 5'd5, 5'd0, 32'hDEADBEEF);
        push(1'b0, 5'd5, 5'd31, 32'd0);
        drain();

        // latency from idle
        push(1'b0, 5'd3, 5'd4, 32'd0);
        chk("lat_push_cycle", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_issue_cycle", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_rsp_cycle", 32'(rsp_valid), 32'd1);
        drain();

        // fill with responses stalled
        rdy_fix = 1'b0;
        for (int i = 0; i < 5; i++)
            push(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 5'($urandom), $urandom);
        chk("full_fifo_count", 32'(fifo_count), 32'd4);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        hs_times.delete();
        rdy_fix = 1'b1;
        drain();
        chk("full_rsp_total", 32'(hs_times.size()), 32'd5);
        for (int i = 1; i < hs_times.size(); i++)
            chk("thru_gap", 32'(hs_times[i] - hs_times[i-1]), 32'd20);

        // randomized traffic with a random consumer
        rdy_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int k;
            logic [4:0] a1, a2;
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            push(1'($urandom_range(0, 1)), a1, a2, $urandom);
            k = $urandom_range(0, 2);
            if (k > 0) begin
                repeat (k) @(posedge clk);
                #1;
            end
        end
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        drain();

        // reset during the ISSUE cycle of a write to reg7
        saved7 = mdl[7];
        push(1'b1, 5'd7, 5'd0, ~saved7);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rf_RegWrite) begin
                found = 1'b1;
                break;
            end
        end
        chk("issue_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl[7] = saved7;
        m_ec = 0;
        exp_pulses--;
        chk("mid_rst_regwrite", 32'(rf_RegWrite), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_reg7", rf_mem[7], saved7);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // saturation of err_count
        for (int i = 0; i < 256; i++) push(1'b1, 5'd0, 5'($urandom), $urandom);
        drain();
        chk("err_count_sat", 32'(err_count), 32'd255);

        // final architectural state
        for (int i = 0; i < 32; i++) chk("final_reg", rf_mem[i], mdl[i]);
        chk("reg0_write_pulses", 32'(n_wr0), 32'd0);
        chk("total_write_pulses", 32'(n_pulse), 32'(exp_pulses));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
